serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial subtractor and inverse of the 4-bit registered adder: recovers B = Sum - A
//   from a (WIDTH+1)-bit sum and a WIDTH-bit operand, one bit per enabled clock.
//   Used in the adder's self-check path: adder output plus original A go in, B comes out.
//   Start/busy/done handshake; enable stalls the operation without losing state.
// PARAMETERS
//   WIDTH  4  operand A width; minuend and difference are WIDTH+1 bits
// PORTS
//   clk       in   1        rising-edge clock
//   rst_n     in   1        asynchronous reset, active low
//   start     in   1        request; sampled only in IDLE
//   enable    in   1        0 = stall (all state held), 1 = advance
//   sum_in    in   WIDTH+1  minuend; captured on accepted start
//   a_in      in   WIDTH    subtrahend, zero-extended; captured on accepted start
//   busy      out  1        1 while in SHIFT or DONE
//   done      out  1        1-cycle pulse; diff, borrow and range_err valid from here on
//   diff      out  WIDTH+1  (sum_in - a_in) mod 2^(WIDTH+1); held until next accepted start
//   borrow    out  1        1 iff sum_in < a_in (unsigned compare)
//   range_err out  1        see CONFIGURATION
// BEHAVIOUR
//   - Reset (rst_n=0, async, any state): state=IDLE; busy, done, diff, borrow, range_err,
//     shift regs, bit counter and borrow FF all cleared. Mid-operation reset aborts with no result.
//   - FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: busy=0. start=1 at an edge: load M<=sum_in, S<={1'b0,a_in}, cnt<=0, br<=0,
//     go to SHIFT. start is not gated by enable. diff/borrow/range_err keep previous values.
//   - SHIFT (busy=1): at each edge with enable=1:
//       d = M[0]^S[0]^br;  nbr = (~M[0]&S[0]) | (~(M[0]^S[0])&br)
//       R <= {d, R[WIDTH:1]};  M, S shift right by 1;  br <= nbr;  cnt <= cnt+1.
//     When cnt==WIDTH at that edge (the last of WIDTH+1 bits): load diff, borrow <= nbr and
//     range_err from the final values, go to DONE. enable=0 holds everything.
//   - DONE: done=1, busy=1 for exactly one cycle, then IDLE on the next edge regardless of enable.
//   - Latency: with enable held high, done is high in the cycle that starts WIDTH+1 edges after
//     the start-sampling edge (5 for WIDTH=4). Each enable=0 cycle in SHIFT adds exactly 1.
//   - start in SHIFT or DONE is ignored and not queued; operand changes after capture have no effect.
//   - Arithmetic: modulo 2^(WIDTH+1); borrow is the final borrow out of the MSB.
//   - Edge cases: sum_in=a_in gives diff=0, borrow=0. sum_in=0, a_in=max gives borrow=1.
//     diff wraps to two's complement on borrow.
// CONFIGURATION
//   RANGE_CHECK_EN defined: range_err <= borrow | diff[WIDTH], loaded at the same edge as diff
//     and held with it. range_err=1 means the result is not a legal WIDTH-bit adder operand B.
//   RANGE_CHECK_EN undefined: range_err tied to 0 and no check logic is built.
//     All other behaviour is identical.
// TESTING (WIDTH=4, enable=1 unless stated)
//   1. sum_in=13, a_in=6, pulse start -> done 5 cycles later, diff=7, borrow=0, range_err=0.
//   2. sum_in=3, a_in=9 -> diff=5'b11010 (26), borrow=1, range_err=1 (EN) / 0 (no EN).
//   3. enable=0 for 3 cycles mid-SHIFT -> done exactly 3 cycles later than in test 1,
//      diff=7 unchanged.
//   4. start re-pulsed during SHIFT with new operands -> ignored, first result delivered;
//      busy falls 1 cycle after done.
//   5. rst_n low for 1 cycle mid-SHIFT -> busy, done, diff and borrow are 0 immediately with no
//      clock edge; no done follows; the next start works normally.
//   6. Round trip: for all A,B in 0..15, drive sum_in=A+B, a_in=A -> diff=B, borrow=0, range_err=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor that recovers B = sum_in - a_in, one bit per enabled
//   clock. It sits in the 4-bit adder's self-check path: the adder's (WIDTH+1)-bit
//   sum and the original A go in, and B comes out.
//   Handshake: start (sampled in IDLE) -> busy -> one-cycle done pulse.
//   enable=0 freezes the operation in SHIFT without losing any state.
//
// Parameters
//   WIDTH      operand A width; minuend and difference are WIDTH+1 bits
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   start      request, sampled only in IDLE
//   enable     0 = stall, 1 = advance (does not gate start)
//   sum_in     minuend, captured on an accepted start
//   a_in       subtrahend (zero-extended), captured on an accepted start
//   busy       high in SHIFT and DONE
//   done       one-cycle pulse; diff/borrow/range_err are valid from here on
//   diff       (sum_in - a_in) mod 2^(WIDTH+1), held until the next accepted start
//   borrow     1 iff sum_in < a_in
//   range_err  borrow | diff[WIDTH] when RANGE_CHECK_EN is defined, else tied 0
//
// Build option
//   RANGE_CHECK_EN  builds the range check. Without it, range_err is constant 0
//                   and no check logic exists.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             enable,
  input  logic [WIDTH:0]   sum_in,
  input  logic [WIDTH-1:0] a_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   diff,
  output logic             borrow,
  output logic             range_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [WIDTH:0] m_q, s_q, r_q;
  logic [CW-1:0]  cnt_q;
  logic           br_q;

  // One full-subtractor slice on the LSBs of the shifting operands.
  logic           d_bit, nbr, last;
  logic [WIDTH:0] r_nxt;

  assign d_bit = m_q[0] ^ s_q[0] ^ br_q;
  assign nbr   = (~m_q[0] & s_q[0]) | (~(m_q[0] ^ s_q[0]) & br_q);
  assign last  = (cnt_q == CW'(WIDTH));
  // Result bits enter at the MSB, so after WIDTH+1 shifts the LSB sits at bit 0.
  assign r_nxt = {d_bit, r_q[WIDTH:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)          state_nxt = SHIFT;
      SHIFT:   if (enable && last) state_nxt = DONE;
      DONE:                        state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= '0;
      s_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        m_q   <= sum_in;
        s_q   <= {1'b0, a_in};
        r_q   <= '0;
        cnt_q <= '0;
        br_q  <= 1'b0;
      end
    end else if (state == SHIFT && enable) begin
      r_q   <= r_nxt;
      m_q   <= m_q >> 1;
      s_q   <= s_q >> 1;
      br_q  <= nbr;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        diff   <= r_nxt;
        borrow <= nbr;
      end
    end
  end

`ifdef RANGE_CHECK_EN
  // A legal WIDTH-bit operand B needs no borrow and a clear top bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               range_err <= 1'b0;
    else if (state == SHIFT && enable && last) range_err <= nbr | d_bit;
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4). The stimulus process pushes
// expected results computed with plain integer arithmetic. A monitor pops and
// compares them on every done pulse. The stimulus process also checks done
// timing against its own count of enabled edges.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk, rst_n, start, enable;
  logic [W:0]   sum_in;
  logic [W-1:0] a_in;
  logic         busy, done, borrow, range_err;
  logic [W:0]   diff;

  typedef struct {
    logic [W:0] diff;
    logic       borrow;
    logic       rerr;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .enable(enable),
    .sum_in(sum_in), .a_in(a_in), .busy(busy), .done(done),
    .diff(diff), .borrow(borrow), .range_err(range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain unsigned arithmetic.
  function automatic exp_t model(input int s, input int a);
    exp_t e;
    e.diff   = 5'((s - a + 32) % 32);
    e.borrow = (s < a);
`ifdef RANGE_CHECK_EN
    e.rerr   = (s < a) || (e.diff >= 16);
`else
    e.rerr   = 1'b0;
`endif
    return e;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1, expected no result pending (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        check("diff", 32'(diff), 32'(e.diff));
        check("borrow", 32'(borrow), 32'(e.borrow));
        check("range_err", 32'(range_err), 32'(e.rerr));
        check("busy_at_done", 32'(busy), 1);
      end
    end
  end

  // mode 0: enable high; 1: 3 stall cycles mid-SHIFT; 2: random enable;
  // 3: enable high, start re-pulsed with other operands during SHIFT.
  task automatic run_op(input int s, input int a, input int mode);
    int   en_cnt, cyc;
    logic en;
    @(negedge clk);
    sum_in = 5'(s);
    a_in   = 4'(a);
    start  = 1'b1;
    enable = 1'($urandom_range(0, 1));
    q.push_back(model(s, a));
    @(negedge clk);
    start  = 1'b0;
    sum_in = 5'($urandom);
    a_in   = 4'($urandom);
    en_cnt = 0;
    cyc    = 0;
    while (en_cnt < W + 1 && cyc < 200) begin
      check("no_early_done", 32'(done), 0);
      case (mode)
        1:       en = !(cyc >= 2 && cyc < 5);
        2:       en = 1'($urandom_range(0, 1));
        default: en = 1'b1;
      endcase
      enable = en;
      if (mode == 3 && cyc == 1) begin
        start  = 1'b1;
        sum_in = 5'($urandom);
        a_in   = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (en) en_cnt++;
    end
    start = 1'b0;
    check("done_latency", 32'(done), 1);
    enable = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("busy_fall", 32'(busy), 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    enable = 1'b0;
    sum_in = '0;
    a_in   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_diff", 32'(diff), 0);
    check("rst_borrow", 32'(borrow), 0);
    check("rst_range_err", 32'(range_err), 0);
    rst_n = 1'b1;

    run_op(13, 6, 0);   // diff 7
    run_op(3, 9, 0);    // wrap to 26 with borrow
    run_op(13, 6, 1);   // 3 stall cycles
    run_op(13, 6, 3);   // ignored restart
    run_op(31, 0, 0);
    run_op(0, 15, 0);
    run_op(9, 9, 0);

    // Reset mid-SHIFT: outputs clear immediately and no done follows.
    @(negedge clk);
    sum_in = 5'd13; a_in = 4'd6; start = 1'b1; enable = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_diff", 32'(diff), 0);
    check("midrst_borrow", 32'(borrow), 0);
    check("midrst_range_err", 32'(range_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(done), 0);
    end
    run_op(13, 6, 0);

    // Round trip through the adder: diff must give back B.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(a + b, a, 0);

    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), 2);

    @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
